// File: rtl/mem_responder.sv
// Unified byte-addressable instruction/data memory with a fixed-latency handshake.
// Define MISALIGN_TRAP_EN to reject misaligned data accesses instead of aligning them.
module mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        d_misalign
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t              state, state_nxt;
    logic [3:0]          cnt, cnt_nxt;
    logic                accept;
    logic                sel_d, we_q;
    logic [2:0]          f3_q;
    logic [ADDR_W-1:0]   addr_q, addr_a;
    logic [31:0]         wdata_q;
    logic [7:0]          mem [DEPTH];

    logic                is_b, is_h, is_w, mis;
    logic [ADDR_W-3:0]   wa;
    logic [1:0]          lane;
    logic [31:0]         rword, load_val, wlanes;
    logic [7:0]          bsel;
    logic [15:0]         hsel;
    logic [3:0]          mask;
    logic                commit;
    logic [31:0]         if_hold, d_hold;
    logic                unused_hi;

    assign unused_hi = ^{d_addr[31:ADDR_W], if_addr[31:ADDR_W]};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (d_req || if_req) begin
                    accept    = 1'b1;
                    cnt_nxt   = 4'(LATENCY - 1);
                    state_nxt = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Data port wins the capture when both request in the same IDLE cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_d   <= 1'b0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            sel_d   <= d_req;
            we_q    <= d_req & d_we;
            f3_q    <= d_funct3;
            addr_q  <= d_req ? d_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
            wdata_q <= d_wdata;
        end
    end

    assign is_b = (f3_q[1:0] == 2'b00);
    assign is_h = (f3_q[1:0] == 2'b01);
    assign is_w = f3_q[1];

`ifdef MISALIGN_TRAP_EN
    assign addr_a = addr_q;
    assign mis    = sel_d & ((is_h & addr_q[0]) | (is_w & (|addr_q[1:0])));
`else
    assign addr_a = is_h ? {addr_q[ADDR_W-1:1], 1'b0}
                  : is_w ? {addr_q[ADDR_W-1:2], 2'b00}
                  : addr_q;
    assign mis    = 1'b0;
`endif

    assign wa    = addr_a[ADDR_W-1:2];
    assign lane  = addr_a[1:0];
    assign rword = {mem[{wa, 2'd3}], mem[{wa, 2'd2}],
                    mem[{wa, 2'd1}], mem[{wa, 2'd0}]};
    assign bsel  = rword[{lane, 3'b000} +: 8];
    assign hsel  = rword[{lane[1], 4'b0000} +: 16];

    always_comb begin
        load_val = rword;
        if (mis)
            load_val = '0;
        else if (is_b)
            load_val = {{24{bsel[7] & ~f3_q[2]}}, bsel};
        else if (is_h)
            load_val = {{16{hsel[15] & ~f3_q[2]}}, hsel};
    end

    assign mask   = is_b ? (4'b0001 << lane)
                  : is_h ? (4'b0011 << lane)
                  : 4'b1111;
    assign wlanes = is_b ? {4{wdata_q[7:0]}}
                  : is_h ? {2{wdata_q[15:0]}}
                  : wdata_q;
    assign commit = (state == RESP) & sel_d & we_q & ~mis;

    // Array is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++)
                if (mask[i]) mem[{wa, 2'(i)}] <= wlanes[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_hold <= '0;
            d_hold  <= '0;
        end else if (state == RESP) begin
            if (sel_d) d_hold  <= load_val;
            else       if_hold <= rword;
        end
    end

    assign d_ready    = (state == RESP) & sel_d;
    assign if_ready   = (state == RESP) & ~sel_d;
    assign d_rdata    = d_ready  ? load_val : d_hold;
    assign if_rdata   = if_ready ? rword    : if_hold;
    assign d_misalign = d_ready & mis;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a byte-array reference model.
// Honours MISALIGN_TRAP_EN in the model the same way the build does.
module tb_mem_responder;

    localparam int ADDR_W  = 10;
    localparam int LATENCY = 2;
    localparam int DEPTH   = 1 << ADDR_W;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [2:0]  d_funct3 = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        d_misalign;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  ref_mem [DEPTH];
    logic [31:0] last_if = '0;
    logic [31:0] last_d  = '0;
    bit          d_known = 1'b1;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3),
        .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .d_misalign(d_misalign)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    // Expected result of an access given the current model contents
    task automatic model(input bit is_d, input logic [2:0] f3,
                         input logic [31:0] addr,
                         output int a, output int s, output bit mis,
                         output logic [31:0] val);
        s   = is_d ? size_of(f3) : 4;
        a   = int'(addr % DEPTH);
        mis = 1'b0;
        val = '0;
        if (is_d && (a % s != 0)) begin
            if (TRAP) mis = 1'b1;
            else      a = a - a % s;
        end
        if (!is_d) a = a - a % 4;
        if (!mis) begin
            for (int i = 0; i < s; i++)
                val = val | (32'(ref_mem[(a + i) % DEPTH]) << (8 * i));
            if (is_d && f3 == 3'b000 && val[7])  val = val | 32'hFFFF_FF00;
            if (is_d && f3 == 3'b001 && val[15]) val = val | 32'hFFFF_0000;
        end
    endtask

    task automatic do_txn(input bit is_d, input bit we,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata);
        int a, s, lat;
        bit mis, xrdy;
        logic [31:0] exp_v, got_v;
        logic        got_m;
        model(is_d, f3, addr, a, s, mis, exp_v);
        @(negedge clk);
        d_req    = is_d;
        if_req   = ~is_d;
        d_we     = we;
        d_funct3 = f3;
        d_addr   = addr;
        if_addr  = addr;
        d_wdata  = wdata;
        @(posedge clk);
        #1;
        d_req   = 1'b0;
        if_req  = 1'b0;
        d_addr  = $urandom;
        if_addr = $urandom;
        d_wdata = $urandom;
        lat   = 0;
        xrdy  = 1'b0;
        got_v = '0;
        got_m = 1'b0;
        for (int k = 1; k <= LATENCY + 3 && lat == 0; k++) begin
            @(negedge clk);
            if (is_d ? if_ready : d_ready) xrdy = 1'b1;
            if (is_d ? d_ready : if_ready) begin
                lat   = k;
                got_v = is_d ? d_rdata : if_rdata;
                got_m = d_misalign;
            end
        end
        chk("latency", lat, LATENCY);
        chk("other_ready", {31'b0, xrdy}, 0);
        if (is_d) begin
            chk("misalign", {31'b0, got_m}, {31'b0, mis});
            if (!we) chk("load", got_v, exp_v);
            chk("if_hold", if_rdata, last_if);
            d_known = !we;
            last_d  = got_v;
            if (we && !mis)
                for (int i = 0; i < s; i++)
                    ref_mem[(a + i) % DEPTH] = wdata[8*i +: 8];
        end else begin
            chk("fetch", got_v, exp_v);
            if (d_known) chk("d_hold", d_rdata, last_d);
            last_if = got_v;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_if_rdata"}, if_rdata, 0);
        chk({tag, "_d_rdata"}, d_rdata, 0);
        chk({tag, "_ready"}, {30'b0, if_ready, d_ready}, 0);
        chk({tag, "_mis"}, {31'b0, d_misalign}, 0);
    endtask

    initial begin
        int a, s, lat_d, lat_if;
        bit mis;
        logic [31:0] exp_d, exp_if, got_d, got_if;

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        for (int w = 0; w < DEPTH / 4; w++)
            do_txn(1'b1, 1'b1, 3'b010, 32'(w * 4), $urandom);

        do_txn(1'b1, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        do_txn(1'b0, 1'b0, 3'b000, 32'h12, 32'h0);
        chk("fetch_const", last_if, 32'hDEAD_BEEF);

        do_txn(1'b1, 1'b1, 3'b010, 32'h20, 32'h0);
        do_txn(1'b1, 1'b1, 3'b000, 32'h21, 32'h0000_0080);
        do_txn(1'b1, 1'b0, 3'b000, 32'h21, 32'h0);
        chk("lb_const", last_d, 32'hFFFF_FF80);
        do_txn(1'b1, 1'b0, 3'b100, 32'h21, 32'h0);
        chk("lbu_const", last_d, 32'h0000_0080);
        do_txn(1'b1, 1'b0, 3'b001, 32'h20, 32'h0);
        chk("lh_const", last_d, 32'hFFFF_8000);

        // Simultaneous requests: data first, fetch after the idle gap
        model(1'b1, 3'b010, 32'h10, a, s, mis, exp_d);
        model(1'b0, 3'b010, 32'h12, a, s, mis, exp_if);
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h10;
        if_req = 1'b1; if_addr = 32'h12;
        @(posedge clk);
        #1;
        d_req = 1'b0;
        lat_d = 0; lat_if = 0; got_d = '0; got_if = '0;
        for (int k = 1; k <= 2 * LATENCY + 4 && lat_if == 0; k++) begin
            @(negedge clk);
            if (d_ready && lat_d == 0) begin
                lat_d = k; got_d = d_rdata;
            end
            if (if_ready) begin
                lat_if = k; got_if = if_rdata; if_req = 1'b0;
            end
        end
        if_req = 1'b0;
        chk("both_lat_d", lat_d, LATENCY);
        chk("both_lat_if", lat_if, 2 * LATENCY + 1);
        chk("both_d", got_d, exp_d);
        chk("both_if", got_if, exp_if);
        last_d = got_d; last_if = got_if; d_known = 1'b1;

        do_txn(1'b1, 1'b1, 3'b010, 32'h13, 32'hCAFE_F00D);
        do_txn(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        chk("mis_word", last_d, TRAP ? 32'hDEAD_BEEF : 32'hCAFE_F00D);

        // Reset during BUSY drops the store
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b010;
        d_addr = 32'h40; d_wdata = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        d_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        rst = 1'b0;
        last_d = '0; last_if = '0; d_known = 1'b1;
        do_txn(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);

        do_txn(1'b1, 1'b1, 3'b010, 32'h400, 32'h1234_5678);
        do_txn(1'b1, 1'b0, 3'b010, 32'h000, 32'h0);
        chk("wrap_const", last_d, 32'h1234_5678);

        for (int t = 0; t < 300; t++)
            do_txn($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                   3'($urandom), $urandom, $urandom);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Byte-addressable, unified instruction/data memory that serves the processor's fetch and load/store requests over a two-port request/ready handshake, with configurable fixed latency. It replaces the combinational instruction and data memories when moving to the pipelined core. It arbitrates fetch against data access, handles byte/half/word sizing from `funct3`, and flags misaligned accesses.

## Interface
Parameters:
- `ADDR_W`, 10: byte-address bits used; memory depth is 2**ADDR_W bytes.
- `LATENCY`, 2: cycles from request acceptance to `ready`. Legal range 1..15.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `if_req`  in  1  fetch request
- `if_addr`  in  32  fetch byte address
- `if_rdata`  out  32  fetched instruction word
- `if_ready`  out  1  one-cycle fetch completion pulse
- `d_req`  in  1  data request
- `d_we`  in  1  1 = store, 0 = load
- `d_funct3`  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `d_addr`  in  32  data byte address
- `d_wdata`  in  32  store data, right-aligned
- `d_rdata`  out  32  load result, sign- or zero-extended
- `d_ready`  out  1  one-cycle data completion pulse
- `d_misalign`  out  1  valid with `d_ready`; access was misaligned

## Operation
- Storage: little-endian byte array, not cleared by reset. Address bits above `ADDR_W-1` are ignored, so addresses wrap modulo 2**ADDR_W.
- FSM states:
  - IDLE: a request may be accepted.
  - BUSY: latency counter running.
  - RESP: ready pulse issued; returns to IDLE.
- IDLE: if `d_req`, accept the data request. Otherwise, if `if_req`, accept the fetch. Data has fixed priority.
- On acceptance: latch the port select, address, `we`, `funct3` and `wdata`. Load counter with `LATENCY-1` and enter BUSY. If `LATENCY`=1, go directly to RESP.
- BUSY: decrement each cycle; at 0, go to RESP.
- RESP:
  - Pulse the selected port's `ready` for exactly one cycle.
  - Read data is valid on that port's `rdata` in that cycle and holds until the next response on the same port.
  - A store commits to the array on the RESP cycle's clock edge.
  - Next state is IDLE.
- Fetches always read an aligned word; `if_addr[1:0]` are ignored.
- Loads: byte/half are selected by `addr[1:0]`, then sign-extended (B, H) or zero-extended (BU, HU).
- Stores: SB writes 1 byte, SH writes 2, SW writes 4. Unlisted `funct3` values are treated as W.
- Requesters hold `req` and operands stable until `ready`. Operand changes after acceptance are ignored. Dropping `req` does not abort a transaction; it still completes.
- A requester whose `req` is high while the other port is served simply waits. There is no starvation guard: back-to-back data requests stall fetch by design.

## Timing
- Reset values: `if_rdata`=0, `d_rdata`=0, `if_ready`=0, `d_ready`=0, `d_misalign`=0, FSM=IDLE, counter=0.
- Latency: request sampled at edge N means `ready` is high in cycle N+`LATENCY`. The earliest next acceptance is edge N+`LATENCY`+1.
- Throughput: one transaction per `LATENCY`+1 cycles.
- Reset asserted mid-transaction: FSM returns to IDLE immediately. No `ready` is issued. A pending store is not committed.
- `d_req` and `if_req` rising on the same edge: the data request is accepted. The fetch is accepted `LATENCY`+1 cycles later if still requested.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - An H/HU access with `addr[0]`=1, or a W access with `addr[1:0]`≠0, completes with `d_misalign`=1 at normal latency.
  - Such a store writes nothing; such a load returns `d_rdata`=0.
- Undefined:
  - `d_misalign` is tied 0.
  - Address low bits are forced to alignment: bit 0 cleared for H/HU; bits 1:0 cleared for W.
  - The access then proceeds normally.

## Test plan
- Reset, `LATENCY`=2, SW 0xDEADBEEF to 0x10 -> `d_ready` 2 cycles after acceptance. Then fetch from 0x12 -> `if_rdata`=0xDEADBEEF.
- SB 0x80 to 0x21, then LB from 0x21 -> 0xFFFFFF80; LBU from 0x21 -> 0x00000080; LH from 0x20 -> 0xFFFF8000 (byte 0x20 previously 0).
- `d_req` and `if_req` asserted on the same edge -> `d_ready` at +2. `if_ready` at +5, after the IDLE gap and a second 2-cycle service.
- With `MISALIGN_TRAP_EN`: SW to 0x13 -> `d_misalign`=1, word at 0x10 unchanged. Without it: same store writes 0x10.
- Store to 0x40 in flight, `rst` pulsed during BUSY -> no `d_ready`, all outputs 0. A later LW from 0x40 returns the old value.
- Address wrap: SW 0x12345678 to 0x400 with `ADDR_W`=10 -> LW from 0x000 returns 0x12345678.
